dma_mc_timing_control: RTL and testbench
========================================

// Module: dma_mc_timing_control
// PURPOSE
//  Multi-channel timing/control FSM for the DMA controller; successor of the single-channel block.
//  Arbitrates NUM_CH DREQ lines with fixed or rotating priority and holds the host bus via HRQ/HLDA.
//  Runs read/write/done cycles with READY wait states in SINGLE, BLOCK or DEMAND mode per channel.
//  Sits between the pins, the register file (modes, TC) and the address/count datapath (strobes).
// PARAMETERS
//  NUM_CH       4    number of channels, 1..8
//  WAIT_MAX     15   max READY-low cycles in S2/S3 before timeout abort; 0 = no timeout
//  ROTATE_PRIO  1    1 = rotating priority (last served lowest), 0 = fixed (ch0 highest)
// PORTS
//  CLK          in   1         clock, all logic on posedge
//  RESET        in   1         synchronous, active-high reset
//  DREQ         in   NUM_CH    channel requests, active-high, sampled each cycle
//  HLDA         in   1         host hold acknowledge
//  READY        in   1         memory/IO ready; low extends S2/S3
//  EOP_in       in   1         external end-of-process, active-high
//  CS           in   1         chip select for programming
//  ch_mode      in   2*NUM_CH  per-channel mode: 00 SINGLE, 01 BLOCK, 10 DEMAND, 11 = BLOCK
//  ch_dir       in   2*NUM_CH  per-channel dir: 00 io_to_mem, 01 mem_to_io, 10 mem_to_mem, 11 verify
//  ch_mask      in   NUM_CH    1 = channel ignored by arbiter
//  ch_tc        in   NUM_CH    terminal count of each channel, from count datapath
//  HRQ          out  1         hold request
//  DACK         out  NUM_CH    one-hot acknowledge of active channel, S1..S4 only
//  IOR,IOW      out  1         IO strobes, valid only when io_oe=1
//  io_oe        out  1         IO strobe drive enable (=HLDA); top level tristates on it
//  MEMR,MEMW    out  1         memory strobes
//  EOP_out      out  1         one-cycle pulse on TC or timeout completion
//  active_ch    out  $clog2(NUM_CH) (min 1)  channel owning the current service
//  state_read, state_write, state_done  out 1 each   S2 / S3 / S4 decode for datapath
//  program_mode out  1         CS & !HLDA
//  timeout_err  out  NUM_CH    sticky per-channel timeout flag; cleared by RESET only
// BEHAVIOUR
//  Reset: state SI, all outputs 0, rotate pointer = ch0, timeout_err = 0.
//  SI: if any DREQ&~ch_mask -> latch winner into active_ch, go S0. Arbitration only in SI.
//  S0: HRQ=1; HLDA -> S1; EOP_in -> SI; else stay.
//  S1: DACK asserted -> S2 (EOP_in -> SI).
//  S2 (read): MEMR if dir mem_to_io/mem_to_mem; IOR if io_to_mem. READY low -> stay, wait counter++.
//  S3 (write): MEMW if io_to_mem/mem_to_mem; IOW if mem_to_io. Same wait rule. verify = no strobes.
//  Wait counter resets on entering S2/S3. Reaching WAIT_MAX with READY low -> timeout_err[ch]=1,
//   EOP_out pulse, -> SI.
//  S4: if ch_tc[active] -> EOP_out pulse, -> SI.
//      SINGLE -> SI (bus released each transfer). BLOCK -> S2.
//      DEMAND -> S2 if DREQ[active] still high, else SI.
//  EOP_in in any state S0..S4 -> SI next cycle, no EOP_out pulse; EOP_in wins over TC same cycle.
//  Rotate pointer advances to active_ch+1 (mod NUM_CH) when a service returns to SI.
//  Masking/deasserting the active channel mid-service does not abort; only EOP_in/TC/timeout/mode end it.
//  HLDA dropping in S1..S4 -> SI (bus lost), no EOP_out.
//  Latency: DREQ -> HRQ 1 cycle; HLDA -> DACK 1 cycle; minimum transfer S2,S3,S4 = 3 cycles.
//  RESET mid-operation: state SI next cycle, all strobes low the same edge.
// STRUCTURE
//  Package dma_mc_pkg: state_t {SI,S0,S1,S2,S3,S4}, mode_t, dir_t encodings.
//  Sub-module dma_prio_arbiter: NUM_CH requests + mask + rotate pointer -> grant index and valid
//   (combinational); FSM, wait counter and pointer register in this module.
// TESTING
//  1 ch0 BLOCK io_to_mem, DREQ0=1, HLDA 1 cycle after HRQ, ch_tc at 3rd S4 -> 3 IOR/MEMW pairs, EOP_out 1 pulse, SI.
//  2 ROTATE_PRIO=1, DREQ=4'b1111 all SINGLE -> services in order ch0,1,2,3,0; fixed prio -> ch0 only.
//  3 ch2 DEMAND, drop DREQ2 during 2nd S3 -> exits after that S4 to SI, no EOP_out.
//  4 READY low 3 cycles in S2, WAIT_MAX=15 -> S2 held 4 cycles, MEMR stable; READY low 15 -> timeout_err, SI.
//  5 EOP_in in S3 same cycle as ch_tc -> SI, MEMW drops next edge, no EOP_out; RESET in S2 -> all outputs 0.
//  6 ch1 masked, DREQ=4'b0010 -> HRQ stays 0; HLDA drop in S2 -> SI, DACK cleared.

Source files
------------

// File: rtl/dma_mc_timing_control_pkg.sv
// Shared encodings for the multi-channel DMA timing/control block.
package dma_mc_pkg;

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE    = 2'b00,
        MODE_BLOCK     = 2'b01,
        MODE_DEMAND    = 2'b10,
        MODE_BLOCK_ALT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        DIR_IO2MEM  = 2'b00,
        DIR_MEM2IO  = 2'b01,
        DIR_MEM2MEM = 2'b10,
        DIR_VERIFY  = 2'b11
    } dir_t;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_mc_timing_control_arbiter.sv
// Combinational channel picker: first unmasked request at or after the start
// channel (rotating) or from channel 0 (fixed).
module dma_prio_arbiter
    import dma_mc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ROTATE_PRIO = 1,
    localparam int CH_W       = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              valid
);

    int idx;

    // Scan from the far end so the nearest eligible channel is written last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ((ROTATE_PRIO != 0 ? int'(ptr) : 0) + i) % NUM_CH;
            if (req[idx[CH_W-1:0]] && !mask[idx[CH_W-1:0]]) begin
                grant = idx[CH_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mc_timing_control.sv
// Multi-channel DMA timing/control: arbitration, bus hold handshake and
// S0..S4 transfer sequencing with READY wait states and timeout abort.
module dma_mc_timing_control
    import dma_mc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WAIT_MAX    = 15,
    parameter int ROTATE_PRIO = 1,
    localparam int CH_W       = idx_width(NUM_CH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic                HLDA,
    input  logic                READY,
    input  logic                EOP_in,
    input  logic                CS,
    input  logic [2*NUM_CH-1:0] ch_mode,
    input  logic [2*NUM_CH-1:0] ch_dir,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [NUM_CH-1:0]   ch_tc,
    output logic                HRQ,
    output logic [NUM_CH-1:0]   DACK,
    output logic                IOR,
    output logic                IOW,
    output logic                io_oe,
    output logic                MEMR,
    output logic                MEMW,
    output logic                EOP_out,
    output logic [CH_W-1:0]     active_ch,
    output logic                state_read,
    output logic                state_write,
    output logic                state_done,
    output logic                program_mode,
    output logic [NUM_CH-1:0]   timeout_err
);

    localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   active_q, ptr_q, grant;
    logic              grant_vld;
    logic [WC_W-1:0]   wait_cnt;
    logic [NUM_CH-1:0] terr_q;
    logic              eop_q;
    mode_t             cur_mode;
    dir_t              cur_dir;
    logic              wait_hit, in_xfer, timeout_now, tc_done;

    dma_prio_arbiter #(.NUM_CH(NUM_CH), .ROTATE_PRIO(ROTATE_PRIO)) u_arb (
        .req   (DREQ),
        .mask  (ch_mask),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_vld)
    );

    assign cur_mode    = mode_t'(ch_mode[{active_q, 1'b0} +: 2]);
    assign cur_dir     = dir_t'(ch_dir[{active_q, 1'b0} +: 2]);
    assign wait_hit    = (WAIT_MAX != 0) && (wait_cnt == WC_W'(WAIT_MAX - 1));
    assign in_xfer     = (state == S2) || (state == S3);
    // Completions only count when the service is not being killed this cycle.
    assign timeout_now = in_xfer && !READY && wait_hit && !EOP_in && HLDA;
    assign tc_done     = (state == S4) && ch_tc[active_q] && !EOP_in && HLDA;

    always_ff @(posedge CLK) begin
        if (RESET) state <= SI;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SI: if (grant_vld) state_nxt = S0;
            S0: if (HLDA) state_nxt = S1;
            S1: state_nxt = S2;
            S2: if (READY) state_nxt = S3; else if (wait_hit) state_nxt = SI;
            S3: if (READY) state_nxt = S4; else if (wait_hit) state_nxt = SI;
            S4: begin
                if (ch_tc[active_q])                 state_nxt = SI;
                else if (cur_mode == MODE_SINGLE)    state_nxt = SI;
                else if (cur_mode == MODE_DEMAND)    state_nxt = DREQ[active_q] ? S2 : SI;
                else                                 state_nxt = S2;
            end
            default: state_nxt = SI;
        endcase
        // External abort or loss of the bus ends any service immediately.
        if (state != SI && (EOP_in || (state != S0 && !HLDA)))
            state_nxt = SI;
    end

    always_comb begin
        HRQ  = 1'b0;
        DACK = '0;
        IOR  = 1'b0;
        IOW  = 1'b0;
        MEMR = 1'b0;
        MEMW = 1'b0;
        case (state)
            S0: HRQ = 1'b1;
            S1, S4: begin
                HRQ            = 1'b1;
                DACK[active_q] = 1'b1;
            end
            S2: begin
                HRQ            = 1'b1;
                DACK[active_q] = 1'b1;
                MEMR           = (cur_dir == DIR_MEM2IO) || (cur_dir == DIR_MEM2MEM);
                IOR            = (cur_dir == DIR_IO2MEM);
            end
            S3: begin
                HRQ            = 1'b1;
                DACK[active_q] = 1'b1;
                MEMW           = (cur_dir == DIR_IO2MEM) || (cur_dir == DIR_MEM2MEM);
                IOW            = (cur_dir == DIR_MEM2IO);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            active_q <= '0;
            ptr_q    <= '0;
            wait_cnt <= '0;
            terr_q   <= '0;
            eop_q    <= 1'b0;
        end else begin
            eop_q <= timeout_now || tc_done;
            if (timeout_now)
                terr_q[active_q] <= 1'b1;
            if (state == SI && grant_vld)
                active_q <= grant;
            // Last-served channel drops to lowest priority once the service ends.
            if (state != SI && state_nxt == SI)
                ptr_q <= (active_q == CH_W'(NUM_CH - 1)) ? '0 : active_q + 1'b1;
            if (in_xfer && state_nxt == state)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    assign EOP_out      = eop_q;
    assign active_ch    = active_q;
    assign timeout_err  = terr_q;
    assign state_read   = (state == S2);
    assign state_write  = (state == S3);
    assign state_done   = (state == S4);
    assign io_oe        = HLDA;
    assign program_mode = CS & ~HLDA;

endmodule

// File: tb/tb_dma_mc_timing_control.sv
// Bench for dma_mc_timing_control: directed vector table, hand sequences for
// wait/abort corners, and random traffic against a transaction-level model.
module tb_dma_mc_timing_control;

    localparam int NUM_CH   = 4;
    localparam int WAIT_MAX = 15;

    logic       CLK = 1'b0;
    logic       RESET, HLDA, READY, EOP_in, CS;
    logic [3:0] DREQ, ch_mask, ch_tc;
    logic [7:0] ch_mode, ch_dir;
    logic       HRQ, IOR, IOW, io_oe, MEMR, MEMW, EOP_out;
    logic       state_read, state_write, state_done, program_mode;
    logic [3:0] DACK, timeout_err;
    logic [1:0] active_ch;
    logic       f_HRQ, f_IOR, f_IOW, f_io_oe, f_MEMR, f_MEMW, f_EOP;
    logic       f_sr, f_sw, f_sd, f_pm;
    logic [3:0] f_DACK, f_terr;
    logic [1:0] f_act;

    always #5 CLK = ~CLK;

    dma_mc_timing_control #(.NUM_CH(NUM_CH), .WAIT_MAX(WAIT_MAX), .ROTATE_PRIO(1)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY), .EOP_in(EOP_in),
        .CS(CS), .ch_mode(ch_mode), .ch_dir(ch_dir), .ch_mask(ch_mask), .ch_tc(ch_tc),
        .HRQ(HRQ), .DACK(DACK), .IOR(IOR), .IOW(IOW), .io_oe(io_oe), .MEMR(MEMR), .MEMW(MEMW),
        .EOP_out(EOP_out), .active_ch(active_ch), .state_read(state_read),
        .state_write(state_write), .state_done(state_done), .program_mode(program_mode),
        .timeout_err(timeout_err));

    dma_mc_timing_control #(.NUM_CH(NUM_CH), .WAIT_MAX(WAIT_MAX), .ROTATE_PRIO(0)) dut_fix (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .READY(READY), .EOP_in(EOP_in),
        .CS(CS), .ch_mode(ch_mode), .ch_dir(ch_dir), .ch_mask(ch_mask), .ch_tc(ch_tc),
        .HRQ(f_HRQ), .DACK(f_DACK), .IOR(f_IOR), .IOW(f_IOW), .io_oe(f_io_oe), .MEMR(f_MEMR),
        .MEMW(f_MEMW), .EOP_out(f_EOP), .active_ch(f_act), .state_read(f_sr),
        .state_write(f_sw), .state_done(f_sd), .program_mode(f_pm), .timeout_err(f_terr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for bus, 2 acknowledged,
    // 3 read, 4 write, 5 finish. m_wait counts READY-low cycles in a phase.
    int       m_ph = 0, m_own = 0, m_ptr = 0, m_wait = 0;
    bit       m_eop = 0;
    bit [3:0] m_terr = 0;

    function automatic int pick();
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (m_ptr + k) % NUM_CH;
            if (DREQ[c] && !ch_mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_clock();
        int ph_n, own_n, c;
        bit eop_n;
        bit [1:0] md;
        if (RESET) begin
            m_ph = 0; m_own = 0; m_ptr = 0; m_wait = 0; m_eop = 0; m_terr = 0;
            return;
        end
        ph_n = m_ph; own_n = m_own; eop_n = 0;
        md = ch_mode[2*m_own +: 2];
        if (m_ph == 0) begin
            c = pick();
            if (c >= 0) begin own_n = c; ph_n = 1; end
        end else if (EOP_in || (m_ph >= 2 && !HLDA)) begin
            ph_n = 0;
        end else if (m_ph == 1) begin
            if (HLDA) ph_n = 2;
        end else if (m_ph == 2) begin
            ph_n = 3;
        end else if (m_ph == 3 || m_ph == 4) begin
            if (READY) ph_n = m_ph + 1;
            else if (WAIT_MAX != 0 && m_wait + 1 >= WAIT_MAX) begin
                ph_n = 0; eop_n = 1; m_terr[m_own] = 1'b1;
            end
        end else begin
            if (ch_tc[m_own]) begin ph_n = 0; eop_n = 1; end
            else if (md == 2'b00) ph_n = 0;
            else if (md == 2'b10) ph_n = DREQ[m_own] ? 3 : 0;
            else ph_n = 3;
        end
        if (m_ph != 0 && ph_n == 0) m_ptr = (m_own + 1) % NUM_CH;
        m_wait = (ph_n == m_ph && (m_ph == 3 || m_ph == 4)) ? m_wait + 1 : 0;
        m_ph = ph_n; m_own = own_n; m_eop = eop_n;
    endtask

    function automatic logic [31:0] model_vec();
        logic [1:0] d;
        logic [3:0] dk;
        bit rd, wr;
        d  = ch_dir[2*m_own +: 2];
        rd = (m_ph == 3);
        wr = (m_ph == 4);
        dk = (m_ph >= 2) ? (4'b0001 << m_own) : 4'b0000;
        return {11'b0, m_ph != 0, dk, rd && d == 2'd0, wr && d == 2'd1,
                rd && (d == 2'd1 || d == 2'd2), wr && (d == 2'd0 || d == 2'd2), m_eop,
                2'(m_own), rd, wr, m_ph == 5, CS && !HLDA, m_terr, HLDA};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {11'b0, HRQ, DACK, IOR, IOW, MEMR, MEMW, EOP_out, active_ch,
                state_read, state_write, state_done, program_mode, timeout_err, io_oe};
    endfunction

    task automatic step();
        model_clock();
        @(posedge CLK);
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        RESET = 1; DREQ = 0; HLDA = 0; READY = 1; EOP_in = 0; CS = 0;
        ch_mask = 0; ch_tc = 0; ch_mode = 0; ch_dir = 0;
        step();
        RESET = 0;
        chk("reset_state", dut_vec(), 32'h0);
    endtask

    typedef struct {
        logic [3:0] dreq;
        logic       hlda, tc;
        logic       hrq;
        logic [3:0] dack;
        logic       ior, memw, eop;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] dq, input logic hl, input logic tc,
                                input logic hr, input logic [3:0] dk,
                                input logic ir, input logic mw, input logic ep);
        vec_t v;
        v.dreq = dq; v.hlda = hl; v.tc = tc; v.hrq = hr; v.dack = dk;
        v.ior = ir; v.memw = mw; v.eop = ep;
        return v;
    endfunction

    vec_t t1[13];
    int   rot_seq[5], fix_seq[5];

    initial begin
        int nsvc;
        bit prev_rd;
        int burst;

        // Block transfer ch0 io_to_mem: three IOR/MEMW pairs, TC in the third S4.
        t1[0]  = mk(4'h1, 0, 0, 1, 4'h0, 0, 0, 0);
        t1[1]  = mk(4'h1, 1, 0, 1, 4'h1, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            t1[2+3*r] = mk(4'h1, 1, 0, 1, 4'h1, 1, 0, 0);
            t1[3+3*r] = mk(4'h1, 1, 0, 1, 4'h1, 0, 1, 0);
            t1[4+3*r] = mk(4'h1, 1, 0, 1, 4'h1, 0, 0, 0);
        end
        t1[11] = mk(4'h0, 1, 1, 0, 4'h0, 0, 0, 1);
        t1[12] = mk(4'h0, 0, 0, 0, 4'h0, 0, 0, 0);

        do_reset();
        ch_mode = 8'b00_00_00_01;
        for (int i = 0; i < 13; i++) begin
            DREQ = t1[i].dreq; HLDA = t1[i].hlda; ch_tc = {3'b0, t1[i].tc};
            step();
            chk($sformatf("t1_row%0d", i), {HRQ, DACK, IOR, MEMW, EOP_out},
                {t1[i].hrq, t1[i].dack, t1[i].ior, t1[i].memw, t1[i].eop});
        end

        // All channels requesting, SINGLE mode: rotating vs fixed service order.
        do_reset();
        DREQ = 4'hF; HLDA = 1;
        nsvc = 0; prev_rd = 0;
        for (int c = 0; c < 60 && nsvc < 5; c++) begin
            step();
            if (state_read && !prev_rd) begin
                rot_seq[nsvc] = active_ch; fix_seq[nsvc] = f_act; nsvc++;
            end
            prev_rd = state_read;
        end
        chk("rot_services", nsvc, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rot_order%0d", i), rot_seq[i], i % 4);
            chk($sformatf("fix_order%0d", i), fix_seq[i], 0);
        end

        // DEMAND ch2: DREQ dropped during the second write ends after that S4.
        do_reset();
        ch_mode = 8'b00_10_00_00; ch_dir = 8'b00_01_00_00;
        DREQ = 4'b0100; HLDA = 1;
        repeat (7) step();
        chk("dem_s3_iow", {state_write, IOW, active_ch}, {1'b1, 1'b1, 2'd2});
        DREQ = 0;
        step();
        chk("dem_s4", state_done, 1);
        step();
        chk("dem_exit", {HRQ, EOP_out}, 2'b00);
        step();
        chk("dem_no_eop", EOP_out, 0);

        // READY wait states in S2, then a full timeout.
        do_reset();
        ch_dir = 8'b00_00_00_01;
        DREQ = 4'h1; HLDA = 1;
        step(); step();
        READY = 0;
        step();
        chk("wait_s2_first", {state_read, MEMR}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("wait_s2_hold%0d", i), {state_read, MEMR}, 2'b11);
        end
        READY = 1;
        step();
        chk("wait_to_s3", state_write, 1);
        DREQ = 0;
        step(); step();
        chk("wait_done_idle", {HRQ, timeout_err}, 5'b0);
        DREQ = 4'h1;
        step(); step();
        READY = 0;
        step();
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            step();
            chk($sformatf("tmo_hold%0d", i), state_read, 1);
        end
        step();
        chk("tmo_abort", {HRQ, timeout_err, EOP_out}, {1'b0, 4'b0001, 1'b1});
        DREQ = 0; READY = 1;
        step();
        chk("tmo_sticky", {timeout_err, EOP_out}, {4'b0001, 1'b0});

        // EOP_in beats TC in S3; then RESET while in S2.
        do_reset();
        ch_mode = 8'b00_00_00_01; ch_dir = 8'b00_00_00_10;
        DREQ = 4'h1; HLDA = 1;
        step(); step(); step();
        chk("eop_s2_memr", MEMR, 1);
        step();
        chk("eop_s3_memw", MEMW, 1);
        EOP_in = 1; ch_tc = 4'h1;
        step();
        chk("eop_abort", {HRQ, MEMW, EOP_out}, 3'b000);
        EOP_in = 0; ch_tc = 0; DREQ = 0;
        step();
        chk("eop_no_pulse", EOP_out, 0);
        DREQ = 4'h1;
        step(); step(); step();
        chk("rst_s2_memr", MEMR, 1);
        RESET = 1;
        step();
        RESET = 0;
        chk("rst_mid", {HRQ, DACK, IOR, IOW, MEMR, MEMW, EOP_out, active_ch,
                        state_read, state_write, state_done, timeout_err}, 32'h0);

        // Masked channel ignored; HLDA loss in S2 drops the service.
        do_reset();
        ch_mask = 4'b0010; DREQ = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mask_hrq%0d", i), HRQ, 0);
        end
        ch_mask = 0; HLDA = 1;
        step(); step(); step();
        chk("hlda_s2", {state_read, DACK}, {1'b1, 4'b0010});
        HLDA = 0; DREQ = 0;
        step();
        chk("hlda_drop", {HRQ, DACK, EOP_out}, 6'b0);

        // Random traffic against the model.
        do_reset();
        burst = 0;
        for (int i = 0; i < 2000; i++) begin
            DREQ    = 4'($urandom);
            if ($urandom_range(15) == 0) ch_mask = 4'($urandom);
            if ($urandom_range(7) == 0) ch_mode = 8'($urandom);
            if ($urandom_range(7) == 0) ch_dir  = 8'($urandom);
            HLDA    = (m_ph != 0) && ($urandom_range(24) != 0);
            if (burst == 0 && $urandom_range(60) == 0) burst = 12 + $urandom_range(6);
            READY   = (burst > 0) ? 1'b0 : ($urandom_range(3) != 0);
            if (burst > 0) burst--;
            EOP_in  = ($urandom_range(40) == 0);
            ch_tc   = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
            CS      = $urandom_range(1);
            RESET   = ($urandom_range(300) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
